uart_rx: RTL

Asynchronous UART receiver, 8N1, LSB first; the receive-side counterpart of the team's uart_tx. It samples the serial line at 16x the baud rate, validates the start bit, majority-votes each bit at mid-bit, and presents each received byte with a one-cycle valid strobe. It sits between the board RX pin and the byte-consuming logic (command parser / loopback to uart_tx).

---
 rtl/uart_defs.sv | 39 +++
 rtl/uart_rx_tick_gen.sv | 33 +++
 rtl/uart_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encodings, oversampling constants
// and the fractional tick increment used by both rx and tx tick generators.
package uart_defs;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMP_A   = 4'd7;
    localparam logic [3:0] SAMP_B   = 4'd8;
    localparam logic [3:0] SAMP_C   = 4'd9;
    localparam logic [3:0] SUB_LAST = 4'd15;

    // round(baud * 16 * 2^acc_w / clk_freq)
    function automatic longint calc_inc(
        input longint clk_freq,
        input longint baud,
        input int     acc_w
    );
        longint num;
        num = baud * longint'(OVERSAMPLE) * (longint'(1) << acc_w);
        return (longint'(2) * num + clk_freq) / (longint'(2) * clk_freq);
    endfunction

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Fractional accumulator producing the 16x oversample tick; the tick is the
// registered carry out, so it is always a single-clk pulse.
module uart_rx_tick_gen
    import uart_defs::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200,
    parameter int ACC_W    = 16
) (
    input  logic clk,
    input  logic rst,
    output logic os_tick
);

    localparam logic [ACC_W-1:0] INC =
        ACC_W'(calc_inc(longint'(clk_freq), longint'(baud), ACC_W));

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, INC};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            os_tick <= 1'b0;
        end else begin
            acc     <= sum[ACC_W-1:0];
            os_tick <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling, 3-sample
// majority vote at mid-bit, one-clk valid / framing-error strobes.
module uart_rx
    import uart_defs::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200,
    parameter int ACC_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    logic rx_m;
    logic rx_s;
    logic os_tick;

    rx_state_e  state, state_n;
    logic [3:0] sub_cnt, sub_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic       s_a, s_a_n;
    logic       s_b, s_b_n;
    logic [7:0] data_n;
    logic       valid_n;
    logic       err_n;
    logic       vote;
    logic       dec;

    uart_rx_tick_gen #(
        .clk_freq(clk_freq),
        .baud    (baud),
        .ACC_W   (ACC_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .os_tick(os_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign vote    = maj3(s_a, s_b, rx_s);
    assign dec     = (sub_cnt == SAMP_C);
    assign rx_busy = (state != RX_IDLE);

    always_comb begin
        state_n = state;
        sub_n   = sub_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        s_a_n   = s_a;
        s_b_n   = s_b;
        data_n  = rx_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (os_tick) begin
            sub_n = sub_cnt + 4'd1;
            if (sub_cnt == SAMP_A) s_a_n = rx_s;
            if (sub_cnt == SAMP_B) s_b_n = rx_s;
            case (state)
                RX_IDLE: begin
                    // the detecting tick is sub-tick 0 of the start bit
                    sub_n = 4'd0;
                    if (!rx_s) begin
                        state_n = RX_START;
                        sub_n   = 4'd1;
                    end
                end
                RX_START: begin
                    if (dec && vote) begin
                        state_n = RX_IDLE;
                        sub_n   = 4'd0;
                    end else if (sub_cnt == SUB_LAST) begin
                        state_n = RX_DATA;
                        bit_n   = 3'd0;
                    end
                end
                RX_DATA: begin
                    if (dec) shift_n = {vote, shift[7:1]};
                    if (sub_cnt == SUB_LAST) begin
                        if (bit_cnt == 3'd7) state_n = RX_STOP;
                        else                 bit_n   = bit_cnt + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (dec) begin
                        sub_n = 4'd0;
                        if (vote) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = RX_IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    sub_n = 4'd0;
                    if (rx_s) state_n = RX_IDLE;
                end
                default: begin
                    state_n = RX_IDLE;
                    sub_n   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            sub_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            s_a          <= 1'b1;
            s_b          <= 1'b1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            sub_cnt      <= sub_n;
            bit_cnt      <= bit_n;
            shift        <= shift_n;
            s_a          <= s_a_n;
            s_b          <= s_b_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
        end
    end

endmodule
